// File: rtl/int_wb_arbiter_pkg.sv
// Shared writeback types for the integer writeback arbiter: result/exception bundles,
// trap causes, and the default FU/port counts.
`ifndef WB_NUM_INT_FU
`define WB_NUM_INT_FU 4
`endif
`ifndef WB_NUM_INT_PORT
`define WB_NUM_INT_PORT 2
`endif

package int_wb_arbiter_pkg;

    localparam int WB_NUM_INT_FU   = `WB_NUM_INT_FU;
    localparam int WB_NUM_INT_PORT = `WB_NUM_INT_PORT;
    localparam int ROB_IDX_W       = 6;
    localparam int XLEN            = 32;

    typedef enum logic [3:0] {
        instAddrMis      = 4'd0,
        instAccessFault  = 4'd1,
        instIllegal      = 4'd2,
        breakpoint       = 4'd3,
        loadAddrMis      = 4'd4,
        loadAccessFault  = 4'd5,
        storeAddrMis     = 4'd6,
        storeAccessFault = 4'd7,
        ecallU           = 4'd8,
        ecallS           = 4'd9,
        ecallM           = 4'd11,
        instPageFault    = 4'd12,
        loadPageFault    = 4'd13,
        storePageFault   = 4'd15
    } rv_trap_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic                 rd_wen;
        logic [4:0]           rd_idx;
        logic [XLEN-1:0]      result;
    } comwbInfo_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        rv_trap_t             except_type;
    } exceptwbInfo_t;

endpackage

// File: rtl/int_wb_arbiter_if.sv
// FU-to-writeback bundle: per-FU results and stalls on one side, registered
// writeback ports toward ROB and regfile on the other.
interface int_wb_arbiter_if import int_wb_arbiter_pkg::*; #(
    parameter int NUM_FU     = WB_NUM_INT_FU,
    parameter int NUM_WBPORT = WB_NUM_INT_PORT
) ();

    logic [NUM_FU-1:0]     i_fu_finished;
    comwbInfo_t            i_comwbInfo    [NUM_FU];
    logic [NUM_FU-1:0]     i_has_except;
    exceptwbInfo_t         i_exceptwbInfo [NUM_FU];
    logic [NUM_FU-1:0]     o_wb_stall;

    logic [NUM_WBPORT-1:0] o_wb_vld;
    comwbInfo_t            o_wb_info        [NUM_WBPORT];
    logic [NUM_WBPORT-1:0] o_wb_rf_wen;
    logic [NUM_WBPORT-1:0] o_wb_except;
    rv_trap_t              o_wb_except_type [NUM_WBPORT];

    modport slave (
        input  i_fu_finished, i_comwbInfo, i_has_except, i_exceptwbInfo,
        output o_wb_stall, o_wb_vld, o_wb_info, o_wb_rf_wen, o_wb_except, o_wb_except_type
    );

    modport master (
        output i_fu_finished, i_comwbInfo, i_has_except, i_exceptwbInfo,
        input  o_wb_stall, o_wb_vld, o_wb_info, o_wb_rf_wen, o_wb_except, o_wb_except_type
    );

endinterface

// File: rtl/int_wb_arbiter_rr_multi_grant.sv
// Combinational round-robin picker: grants the first M requesters scanning from ptr_i,
// the k-th grant in scan order landing on port k.
module int_wb_arbiter_rr_multi_grant #(
    parameter  int N  = 4,
    parameter  int M  = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] port_sel_o [M],
    output logic [M-1:0]  port_vld_o,
    output logic [IW-1:0] last_idx_o
);

    // NOTE: every output gets a default at the top so no path through the loops infers a latch.
    always_comb begin
        logic [IW-1:0] idx;
        idx        = '0;
        grant_o    = '0;
        port_vld_o = '0;
        last_idx_o = '0;
        for (int k = 0; k < M; k++) begin
            port_sel_o[k] = '0;
        end
        // Each port takes the first not-yet-granted requester in scan order.
        for (int k = 0; k < M; k++) begin
            for (int s = 0; s < N; s++) begin
                idx = IW'((int'(ptr_i) + s) % N);
                if (!port_vld_o[k] && req_i[idx] && !grant_o[idx]) begin
                    grant_o[idx]  = 1'b1;
                    port_vld_o[k] = 1'b1;
                    port_sel_o[k] = idx;
                    last_idx_o    = idx;
                end
            end
        end
    end

endmodule

// File: rtl/int_wb_arbiter.sv
// Integer writeback arbiter: round-robin grants FU results onto registered writeback ports.
// Define WB_ARB_PERFCNT_EN to add saturating stall/full-cycle performance counters.
module int_wb_arbiter import int_wb_arbiter_pkg::*; #(
    parameter int NUM_FU     = WB_NUM_INT_FU,
    parameter int NUM_WBPORT = WB_NUM_INT_PORT
) (
    input logic              clk,
    input logic              rst,
    int_wb_arbiter_if.slave  bus
`ifdef WB_ARB_PERFCNT_EN
    ,
    output logic [31:0]      o_perf_stall_cycles,
    output logic [31:0]      o_perf_full_cycles
`endif
);

    localparam int IW = $clog2(NUM_FU);

    logic [NUM_FU-1:0]     req;
    logic [NUM_FU-1:0]     grant;
    logic [NUM_FU-1:0]     stall;
    logic [IW-1:0]         port_sel [NUM_WBPORT];
    logic [NUM_WBPORT-1:0] port_vld;
    logic [IW-1:0]         last_idx;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;

    logic [NUM_WBPORT-1:0] wb_vld_q, wb_rf_wen_q, wb_except_q;
    comwbInfo_t            wb_info_q        [NUM_WBPORT];
    rv_trap_t              wb_except_type_q [NUM_WBPORT];

    assign req = bus.i_fu_finished;

    int_wb_arbiter_rr_multi_grant #(.N(NUM_FU), .M(NUM_WBPORT)) u_pick (
        .req_i      (req),
        .ptr_i      (rr_ptr_q),
        .grant_o    (grant),
        .port_sel_o (port_sel),
        .port_vld_o (port_vld),
        .last_idx_o (last_idx)
    );

    assign stall          = rst ? '0 : (req & ~grant);
    assign bus.o_wb_stall = stall;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (|grant) begin
            rr_ptr_d = (last_idx == IW'(NUM_FU - 1)) ? '0 : last_idx + IW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            wb_vld_q    <= '0;
            wb_rf_wen_q <= '0;
            wb_except_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wb_vld_q <= port_vld;
            for (int k = 0; k < NUM_WBPORT; k++) begin
                wb_rf_wen_q[k] <= port_vld[k] && bus.i_comwbInfo[port_sel[k]].rd_wen;
                wb_except_q[k] <= port_vld[k] && bus.i_has_except[port_sel[k]];
            end
        end
    end

    // NOTE: payload registers carry no reset; they are qualified by the reset control bits above.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_WBPORT; k++) begin
            if (port_vld[k]) begin
                wb_info_q[k]        <= bus.i_comwbInfo[port_sel[k]];
                wb_except_type_q[k] <= bus.i_exceptwbInfo[port_sel[k]].except_type;
            end
        end
    end

    assign bus.o_wb_vld         = wb_vld_q;
    assign bus.o_wb_info        = wb_info_q;
    assign bus.o_wb_rf_wen      = wb_rf_wen_q;
    assign bus.o_wb_except      = wb_except_q;
    assign bus.o_wb_except_type = wb_except_type_q;

`ifdef WB_ARB_PERFCNT_EN
    logic [31:0] perf_stall_q, perf_full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_full_q  <= '0;
        end else begin
            if ((|stall) && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
            if ((&port_vld) && (perf_full_q != '1)) perf_full_q <= perf_full_q + 32'd1;
        end
    end

    assign o_perf_stall_cycles = perf_stall_q;
    assign o_perf_full_cycles  = perf_full_q;
`endif

`ifndef SYNTHESIS
    a_except_needs_finish: assert property (@(posedge clk) disable iff (rst)
        (bus.i_has_except & ~bus.i_fu_finished) == '0);

    a_vld_contiguous: assert property (@(posedge clk) disable iff (rst)
        (wb_vld_q & (wb_vld_q + NUM_WBPORT'(1))) == '0);

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu_chk
        a_except_rob_match: assert property (@(posedge clk) disable iff (rst)
            bus.i_has_except[i] |-> bus.i_exceptwbInfo[i].rob_idx == bus.i_comwbInfo[i].rob_idx);
    end

    for (genvar k = 0; k < NUM_WBPORT; k++) begin : g_port_chk
        for (genvar j = k + 1; j < NUM_WBPORT; j++) begin : g_pair
            a_one_grant_per_fu: assert property (@(posedge clk) disable iff (rst)
                !(port_vld[k] && port_vld[j] && (port_sel[k] == port_sel[j])));
        end
    end
`endif

endmodule

// File: tb/tb_int_wb_arbiter.sv
// Bench for int_wb_arbiter: directed vector table, multi-cycle corner sequences and
// random traffic, with a queue of expected writeback-port contents one cycle behind.
module tb_int_wb_arbiter;
    import int_wb_arbiter_pkg::*;

    localparam int NF = 4;
    localparam int NP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int_wb_arbiter_if #(.NUM_FU(NF), .NUM_WBPORT(NP)) bus ();

`ifdef WB_ARB_PERFCNT_EN
    logic [31:0] perf_stall, perf_full;
`endif

    int_wb_arbiter #(.NUM_FU(NF), .NUM_WBPORT(NP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef WB_ARB_PERFCNT_EN
        ,
        .o_perf_stall_cycles (perf_stall),
        .o_perf_full_cycles  (perf_full)
`endif
    );

    typedef struct packed {
        logic [1:0]      vld;
        logic [1:0]      rf_wen;
        logic [1:0]      exc;
        logic [1:0][5:0] rob;
        logic [1:0][3:0] etype;
        logic [1:0]      ptr;
    } sb_t;

    typedef struct {
        logic [3:0] fin;
        logic [3:0] exc;
        logic [3:0] rdw;
        logic [5:0] base;
        logic [3:0] stall;
        int         f0;
        int         f1;
        logic [1:0] ptr;
    } vec_t;

    sb_t        sb_q  [$];
    string      tag_q [$];
    vec_t       tbl   [10];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] mdl_ptr = 2'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_compare();
        sb_t   e;
        string t;
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check({t, "_vld"},    64'(bus.o_wb_vld),    64'(e.vld));
        check({t, "_rfwen"},  64'(bus.o_wb_rf_wen), 64'(e.rf_wen));
        check({t, "_except"}, 64'(bus.o_wb_except), 64'(e.exc));
        check({t, "_ptr"},    64'(dut.rr_ptr_q),    64'(e.ptr));
        for (int k = 0; k < NP; k++) begin
            if (e.vld[k]) begin
                check($sformatf("%s_rob%0d", t, k), 64'(bus.o_wb_info[k].rob_idx), 64'(e.rob[k]));
                if (e.exc[k])
                    check($sformatf("%s_etype%0d", t, k), 64'(bus.o_wb_except_type[k]), 64'(e.etype[k]));
            end
        end
    endtask

    // One clock: compare last cycle's outputs, drive new requests, check stall, queue expectations.
    task automatic cycle(input logic r, input logic [3:0] fin, input logic [3:0] exc,
                         input logic [3:0] rdw, input logic [5:0] base, input logic [3:0] exp_stall,
                         input int f0, input int f1, input logic [1:0] exp_ptr, input string tag);
        sb_t           e;
        int            fu;
        comwbInfo_t    c;
        exceptwbInfo_t x;
        @(negedge clk);
        pop_compare();
        rst = r;
        for (int i = 0; i < NF; i++) begin
            c.rob_idx     = base + 6'(i);
            c.rd_wen      = rdw[i];
            c.rd_idx      = 5'(i + 1);
            c.result      = 32'hC0DE_0000 + 32'(i);
            x.rob_idx     = c.rob_idx;
            x.except_type = exc[i] ? instIllegal : loadAddrMis;
            bus.i_comwbInfo[i]    = c;
            bus.i_exceptwbInfo[i] = x;
            bus.i_fu_finished[i]  = fin[i];
            bus.i_has_except[i]   = exc[i];
        end
        #1;
        check({tag, "_stall"}, 64'(bus.o_wb_stall), 64'(exp_stall));
        e     = '0;
        e.ptr = r ? 2'd0 : exp_ptr;
        if (!r) begin
            for (int k = 0; k < NP; k++) begin
                fu = (k == 0) ? f0 : f1;
                if (fu >= 0) begin
                    e.vld[k]    = 1'b1;
                    e.rob[k]    = base + 6'(fu);
                    e.rf_wen[k] = rdw[fu];
                    e.exc[k]    = exc[fu];
                    e.etype[k]  = 4'(instIllegal);
                end
            end
        end
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    function automatic void model(input logic [1:0] ptr, input logic [3:0] fin,
                                  output logic [3:0] stall, output int f0, output int f1,
                                  output logic [1:0] nptr);
        int         order [$];
        logic [3:0] g;
        g = '0;
        for (int s = 0; s < NF; s++) begin
            int i;
            i = (int'(ptr) + s) % NF;
            if (fin[i]) order.push_back(i);
        end
        f0   = (order.size() > 0) ? order[0] : -1;
        f1   = (order.size() > 1) ? order[1] : -1;
        nptr = ptr;
        if (f0 >= 0) begin g[f0] = 1'b1; nptr = 2'((f0 + 1) % NF); end
        if (f1 >= 0) begin g[f1] = 1'b1; nptr = 2'((f1 + 1) % NF); end
        stall = fin & ~g;
    endfunction

    task automatic run_model(input logic [3:0] fin, input logic [3:0] exc, input logic [3:0] rdw,
                             input logic [5:0] base, input string tag);
        logic [3:0] st;
        int         f0, f1;
        logic [1:0] np;
        model(mdl_ptr, fin, st, f0, f1, np);
        cycle(1'b0, fin, exc, rdw, base, st, f0, f1, np, tag);
        mdl_ptr = np;
    endtask

    task automatic reset_cycle(input logic [3:0] fin, input string tag);
        cycle(1'b1, fin, 4'b0, 4'b0, 6'd0, 4'b0, -1, -1, 2'd0, tag);
        mdl_ptr = 2'd0;
    endtask

    initial begin
        int granted [NF];
        int run     [NF];
        int max_run;
        logic [3:0] rf, re;

        for (int i = 0; i < NF; i++) begin
            bus.i_fu_finished[i]  = 1'b0;
            bus.i_has_except[i]   = 1'b0;
            bus.i_comwbInfo[i]    = '0;
            bus.i_exceptwbInfo[i] = '0;
        end

        //          fin      exc      rdw      base   stall    f0  f1  ptr
        tbl[0] = '{4'b0011, 4'b0000, 4'b1111, 6'd5,  4'b0000,  0,  1, 2'd2};
        tbl[1] = '{4'b0100, 4'b0000, 4'b1111, 6'd12, 4'b0000,  2, -1, 2'd3};
        tbl[2] = '{4'b1001, 4'b0000, 4'b1111, 6'd20, 4'b0000,  3,  0, 2'd1};
        tbl[3] = '{4'b0010, 4'b0010, 4'b0000, 6'd8,  4'b0000,  1, -1, 2'd2};
        tbl[4] = '{4'b0000, 4'b0000, 4'b0000, 6'd0,  4'b0000, -1, -1, 2'd2};
        tbl[5] = '{4'b1111, 4'b0000, 4'b1010, 6'd30, 4'b0011,  2,  3, 2'd0};
        tbl[6] = '{4'b0111, 4'b0000, 4'b1111, 6'd40, 4'b0100,  0,  1, 2'd2};
        tbl[7] = '{4'b0100, 4'b0000, 4'b1111, 6'd40, 4'b0000,  2, -1, 2'd3};
        tbl[8] = '{4'b0000, 4'b0000, 4'b0000, 6'd0,  4'b0000, -1, -1, 2'd3};
        tbl[9] = '{4'b0101, 4'b0100, 4'b0001, 6'd50, 4'b0000,  0,  2, 2'd3};

        reset_cycle(4'b0000, "rst0");
        reset_cycle(4'b0000, "rst1");

        for (int v = 0; v < 10; v++) begin
            cycle(1'b0, tbl[v].fin, tbl[v].exc, tbl[v].rdw, tbl[v].base, tbl[v].stall,
                  tbl[v].f0, tbl[v].f1, tbl[v].ptr, $sformatf("vec%0d", v));
        end

        // All FUs requesting back to back: fairness and bounded stall.
        reset_cycle(4'b0000, "rst_stream");
        max_run = 0;
        for (int i = 0; i < NF; i++) begin
            granted[i] = 0;
            run[i]     = 0;
        end
        for (int c = 0; c < 4; c++) begin
            run_model(4'b1111, 4'b0000, 4'b1111, 6'(10 * c), $sformatf("stream%0d", c));
            for (int i = 0; i < NF; i++) begin
                if (bus.o_wb_stall[i]) run[i]++;
                else begin
                    granted[i]++;
                    run[i] = 0;
                end
                if (run[i] > max_run) max_run = run[i];
            end
        end
        run_model(4'b0000, 4'b0000, 4'b0000, 6'd0, "stream_drain");
        for (int i = 0; i < NF; i++) check($sformatf("stream_grants_fu%0d", i), 64'(granted[i]), 64'd2);
        check("stream_max_stall_run", 64'(max_run), 64'd1);
`ifdef WB_ARB_PERFCNT_EN
        check("perf_stall_cycles", 64'(perf_stall), 64'd4);
        check("perf_full_cycles",  64'(perf_full),  64'd4);
`endif

        // Reset while FUs are stalled: stalls drop immediately, nothing emerges afterwards.
        run_model(4'b1111, 4'b0000, 4'b1111, 6'd60 - 6'd4, "pre_rst");
        reset_cycle(4'b1111, "mid_rst");
        run_model(4'b0000, 4'b0000, 4'b0000, 6'd0, "post_rst0");
        run_model(4'b0100, 4'b0100, 4'b0100, 6'd33, "post_rst1");

        for (int n = 0; n < 24; n++) begin
            rf = 4'($urandom_range(0, 15));
            re = 4'($urandom) & rf;
            run_model(rf, re, 4'($urandom), 6'($urandom_range(0, 59)), $sformatf("rnd%0d", n));
        end

        run_model(4'b0000, 4'b0000, 4'b0000, 6'd0, "drain0");
        run_model(4'b0000, 4'b0000, 4'b0000, 6'd0, "drain1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
